spi_ram_cmd_master: RTL and testbench
=====================================

SPI_RAM_CMD_MASTER -- requirements
Module: spi_ram_cmd_master

Interface
REQ-001 Parameter ADDR_SIZE, default 8, address and data width of RAM words.
REQ-002 Parameter TIMEOUT, default 15, max RWAIT cycles before read error.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted this cycle when req_valid also high.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_SIZE  target address.
REQ-009 req_wdata  input  ADDR_SIZE  write data.
REQ-010 rsp_valid  output  1  response available; held until rsp_ready.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_rdata  output  ADDR_SIZE  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  read timeout.
REQ-014 ram_din  output  ADDR_SIZE+2  command word to RAM: [9:8] opcode, [7:0] payload.
REQ-015 ram_rx_valid  output  1  command word valid, one cycle per word.
REQ-016 ram_dout  input  ADDR_SIZE  RAM read data.
REQ-017 ram_tx_valid  input  1  RAM read data valid.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The block SHALL implement FSM states IDLE, WADDR, WDATA, RADDR, RCMD, RWAIT, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE with rst low; handshake = req_valid & req_ready; req_write, req_addr, req_wdata SHALL be captured on handshake.
REQ-021 Opcodes: WADDR drives 00+addr, WDATA 01+wdata, RADDR 10+addr, RCMD 11+0x00; each state SHALL last exactly one cycle with ram_rx_valid=1.
REQ-022 Outside WADDR/WDATA/RADDR/RCMD, ram_rx_valid SHALL be 0 and ram_din SHALL be 0.
REQ-023 Shadow registers wa_shadow/ra_shadow with valid flags SHALL record last address sent with opcode 00/10.
REQ-024 Write: IDLE -> WADDR -> WDATA -> RESP; WADDR SHALL be skipped when wa_valid and wa_shadow == req_addr.
REQ-025 Read: IDLE -> RADDR -> RCMD -> RWAIT -> RESP; RADDR SHALL be skipped when ra_valid and ra_shadow == req_addr.
REQ-026 Latency from handshake cycle T: write rsp_valid at T+3 (T+2 on shadow hit); read rsp_valid at T+4 (T+3 on hit) when RAM answers in first RWAIT cycle.
REQ-027 ram_tx_valid SHALL be sampled only in RWAIT; its value in RCMD or earlier SHALL be ignored (stale from prior read).
REQ-028 In RWAIT, ram_tx_valid=1 SHALL capture ram_dout into rsp_rdata, rsp_err=0, go to RESP.
REQ-029 RWAIT counter SHALL start at 0 on entry; after TIMEOUT cycles without ram_tx_valid, rsp_rdata=0, rsp_err=1, go to RESP, clear wa_valid and ra_valid.
REQ-030 In RESP, rsp_valid=1; rsp_valid & rsp_ready SHALL return to IDLE next cycle; rsp_rdata/rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-031 Outside RESP, rsp_valid SHALL be 0.
REQ-032 A new request SHALL NOT be accepted in the cycle rsp completes; earliest next handshake is the following cycle in IDLE.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_rx_valid=0, ram_din=0, busy=0, wa_valid=0, ra_valid=0, RWAIT counter=0.
REQ-034 rst asserted mid-operation SHALL abort the transaction with no response and no further RAM words.
REQ-035 After rst deassert, first cycle SHALL be IDLE with req_ready=1.

Verification
REQ-036 Write 0x3C to 0x12 after reset -> ram_din 0x012 then 0x13C on consecutive cycles, rsp_valid at T+3, rsp_err=0.
REQ-037 Second write 0x55 to 0x12 -> only 0x155 issued, rsp_valid at T+2.
REQ-038 Read 0x12 against behavioral RAM -> 0x212, 0x300, rsp_rdata=0x3C at T+4; repeat read -> only 0x300, rsp at T+3.
REQ-039 Read with ram_tx_valid held low -> rsp_err=1, rsp_rdata=0 after 15 RWAIT cycles; next write re-sends address word.
REQ-040 rsp_ready low 5 cycles -> rsp_valid, rsp_rdata stable, req_ready=0 throughout.
REQ-041 rst pulse during WDATA -> ram_rx_valid=0 same cycle, no rsp_valid, req_ready=1 first cycle after release.

Source files
------------

// File: rtl/spi_ram_cmd_master.sv
// Request/response front end that turns RAM reads and writes into 2-bit-opcode command words,
// skipping address words that repeat the last address sent.
module spi_ram_cmd_master #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, RADDR, RCMD, RWAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] addr_q, wdata_q;
  logic [ADDR_SIZE-1:0] wa_shadow, ra_shadow;
  logic                 wa_valid, ra_valid;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 hs, wa_hit, ra_hit, rd_timeout;

  assign req_ready  = (state == IDLE) && !rst;
  assign hs         = req_valid && req_ready;
  assign wa_hit     = wa_valid && (wa_shadow == req_addr);
  assign ra_hit     = ra_valid && (ra_shadow == req_addr);
  assign rd_timeout = (state == RWAIT) && !ram_tx_valid &&
                      (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) begin
          if (req_write) state_nxt = wa_hit ? WDATA : WADDR;
          else           state_nxt = ra_hit ? RCMD  : RADDR;
        end
      end
      WADDR: state_nxt = WDATA;
      WDATA: state_nxt = RESP;
      RADDR: state_nxt = RCMD;
      RCMD:  state_nxt = RWAIT;
      RWAIT: if (ram_tx_valid || rd_timeout) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_din      = '0;
    ram_rx_valid = 1'b0;
    rsp_valid    = 1'b0;
    busy         = (state != IDLE);
    case (state)
      WADDR: begin ram_rx_valid = 1'b1; ram_din = {2'b00, addr_q};  end
      WDATA: begin ram_rx_valid = 1'b1; ram_din = {2'b01, wdata_q}; end
      RADDR: begin ram_rx_valid = 1'b1; ram_din = {2'b10, addr_q};  end
      RCMD:  begin ram_rx_valid = 1'b1; ram_din = {2'b11, {ADDR_SIZE{1'b0}}}; end
      RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request fields and shadow addresses are qualified by state/valid flags, so they need no reset.
  always_ff @(posedge clk) begin
    if (hs) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state == WADDR) wa_shadow <= addr_q;
    if (state == RADDR) ra_shadow <= addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_valid  <= 1'b0;
      ra_valid  <= 1'b0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      wait_cnt <= (state == RWAIT) ? wait_cnt + 1'b1 : '0;
      if (state == WADDR) wa_valid <= 1'b1;
      if (state == RADDR) ra_valid <= 1'b1;
      if (hs) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
      if (state == RWAIT && ram_tx_valid) begin
        rsp_rdata <= ram_dout;
        rsp_err   <= 1'b0;
      end else if (rd_timeout) begin
        // A lost read leaves the RAM's address state unknown, so both shadows are dropped.
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        wa_valid  <= 1'b0;
        ra_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_cmd_master.sv
// Directed bench for spi_ram_cmd_master with a small behavioural command-word RAM.
module tb_spi_ram_cmd_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [7:0] rsp_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid, busy;
  logic [7:0] ram_dout = '0;
  logic       model_tx = 1'b0, stale_tx = 1'b0, mute = 1'b0;
  logic [7:0] mem [0:255];
  logic [7:0] m_waddr = '0, m_raddr = '0;
  int         n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign ram_tx_valid = model_tx | stale_tx;

  spi_ram_cmd_master #(.ADDR_SIZE(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid), .busy(busy)
  );

  // Behavioural RAM: answers an opcode-11 word with data in the following cycle.
  always @(posedge clk) begin
    model_tx <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: m_waddr <= ram_din[7:0];
        2'b01: mem[m_waddr] <= ram_din[7:0];
        2'b10: m_raddr <= ram_din[7:0];
        default: if (!mute) begin
          model_tx <= 1'b1;
          ram_dout <= mem[m_raddr];
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step;
    req_valid = 1'b0;
    chk("busy_active", 32'(busy), 32'd1);
  endtask

  task automatic finish_rsp(input logic [7:0] exp_d, input logic exp_e, input int hold);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
      chk("hold_rsp_err", 32'(rsp_err), 32'(exp_e));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic hit, input int hold);
    issue(1'b1, a, d);
    if (!hit) begin
      chk("waddr_rx_valid", 32'(ram_rx_valid), 32'd1);
      chk("waddr_word", 32'(ram_din), 32'({2'b00, a}));
      step;
    end
    chk("wdata_rx_valid", 32'(ram_rx_valid), 32'd1);
    chk("wdata_word", 32'(ram_din), 32'({2'b01, d}));
    chk("wdata_rsp_valid", 32'(rsp_valid), 32'd0);
    step;
    finish_rsp(8'h00, 1'b0, hold);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp_d, input logic hit,
                         input logic err, input logic stale, input int hold);
    stale_tx = stale;
    issue(1'b0, a, 8'h00);
    if (!hit) begin
      chk("raddr_rx_valid", 32'(ram_rx_valid), 32'd1);
      chk("raddr_word", 32'(ram_din), 32'({2'b10, a}));
      step;
    end
    chk("rcmd_rx_valid", 32'(ram_rx_valid), 32'd1);
    chk("rcmd_word", 32'(ram_din), 32'h300);
    step;
    stale_tx = 1'b0;
    chk("rwait_rx_valid", 32'(ram_rx_valid), 32'd0);
    chk("rwait_din", 32'(ram_din), 32'd0);
    chk("rwait_rsp_valid", 32'(rsp_valid), 32'd0);
    if (err) begin
      for (int i = 1; i < 15; i++) begin
        step;
        chk("rwait_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rwait_hold_busy", 32'(busy), 32'd1);
      end
    end
    step;
    finish_rsp(exp_d, err, hold);
  endtask

  initial begin
    step;
    step;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);

    do_write(8'h12, 8'h3C, 1'b0, 0);
    do_read (8'h12, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    do_read (8'h12, 8'h3C, 1'b1, 1'b0, 1'b0, 0);
    do_write(8'h12, 8'h55, 1'b1, 0);
    do_read (8'h12, 8'h55, 1'b1, 1'b0, 1'b0, 5);
    do_write(8'h40, 8'hA5, 1'b0, 0);
    do_read (8'h40, 8'hA5, 1'b0, 1'b0, 1'b0, 0);

    // Silent RAM plus a stale ram_tx_valid before RWAIT: must still time out.
    mute = 1'b1;
    do_read (8'h77, 8'h00, 1'b0, 1'b1, 1'b1, 0);
    mute = 1'b0;
    do_write(8'h12, 8'h66, 1'b0, 0);
    do_read (8'h12, 8'h66, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of a write's data word.
    issue(1'b1, 8'h30, 8'h99);
    chk("abort_waddr_word", 32'(ram_din), 32'h030);
    step;
    chk("abort_wdata_word", 32'(ram_din), 32'h199);
    rst = 1'b1;
    #1;
    chk("abort_rx_valid", 32'(ram_rx_valid), 32'd0);
    chk("abort_din", 32'(ram_din), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    step;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_release_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("abort_quiet_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_quiet_rx", 32'(ram_rx_valid), 32'd0);
    end
    do_write(8'h12, 8'h77, 1'b0, 0);
    do_read (8'h12, 8'h77, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
